// File: rtl/branch_pkg.sv
// Shared types for the OTTER branch unit: opcodes, branch funct3
// codes, redirect codes and the predictor counter reset value.
package branch_pkg;

    typedef enum logic [6:0] {
        LUI    = 7'b0110111,
        AUIPC  = 7'b0010111,
        JAL    = 7'b1101111,
        JALR   = 7'b1100111,
        BRANCH = 7'b1100011,
        LOAD   = 7'b0000011,
        STORE  = 7'b0100011,
        OP_IMM = 7'b0010011,
        OP_RG3 = 7'b0110011,
        SYS    = 7'b1110011
    } opcode_t;

    typedef enum logic [2:0] {
        BEQ  = 3'b000,
        BNE  = 3'b001,
        BLT  = 3'b100,
        BGE  = 3'b101,
        BLTU = 3'b110,
        BGEU = 3'b111
    } br_func3_t;

    typedef enum logic [1:0] {
        REDIR_NONE   = 2'b00,
        REDIR_TARGET = 2'b01,
        REDIR_SEQ    = 2'b10
    } redir_t;

    localparam logic [1:0] CNT_RESET = 2'b01;

endpackage

// File: rtl/bht_2bit.sv
// Bimodal history table of 2-bit saturating counters.
// Async read for fetch, sync saturating update from execute.
module bht_2bit
    import branch_pkg::*;
#(
    parameter int DEPTH = 64,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [1:0]       rd_cnt,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken
);

    logic [1:0] cnt [DEPTH];

    assign rd_cnt = cnt[rd_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                cnt[i] <= CNT_RESET;
        end else if (wr_en) begin
            if (wr_taken && cnt[wr_idx] != 2'b11)
                cnt[wr_idx] <= cnt[wr_idx] + 2'd1;
            else if (!wr_taken && cnt[wr_idx] != 2'b00)
                cnt[wr_idx] <= cnt[wr_idx] - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Execute-stage branch resolution with bimodal prediction,
// registered redirect/flush pulses and saturating statistics.
module branch_predict_unit
    import branch_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int BHT_DEPTH = 64,
    parameter int CNT_W     = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [XLEN-1:0]  if_pc,
    output logic             if_pred_taken,
    input  logic             ex_valid,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic [6:0]       ex_opcode,
    input  logic [2:0]       ex_func3,
    input  logic [XLEN-1:0]  ex_rs1,
    input  logic [XLEN-1:0]  ex_rs2,
    input  logic             ex_pred_taken,
    output logic [1:0]       br_redir,
    output logic             br_flush,
    output logic             br_taken,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam int IDX_W = $clog2(BHT_DEPTH);
    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0] rd_cnt;
    logic       eq, lt, ltu;
    logic       taken_c, cond_c, train_c;
    redir_t     redir_c;

    // Only the word-index bits of either PC select a counter.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{if_pc[XLEN-1:IDX_W+2], if_pc[1:0],
                              ex_pc[XLEN-1:IDX_W+2], ex_pc[1:0]};

    bht_2bit #(.DEPTH(BHT_DEPTH)) u_bht (
        .clk      (CLK),
        .rst      (RST),
        .rd_idx   (if_pc[IDX_W+1:2]),
        .rd_cnt   (rd_cnt),
        .wr_en    (train_c),
        .wr_idx   (ex_pc[IDX_W+1:2]),
        .wr_taken (taken_c)
    );

    assign if_pred_taken = rd_cnt[1];

    assign eq  = ex_rs1 == ex_rs2;
    assign lt  = $signed(ex_rs1) < $signed(ex_rs2);
    assign ltu = ex_rs1 < ex_rs2;

    always_comb begin
        taken_c = 1'b0;
        cond_c  = 1'b1;
        train_c = 1'b0;
        redir_c = REDIR_NONE;
        if (ex_valid) begin
            case (ex_opcode)
                BRANCH: begin
                    case (ex_func3)
                        BEQ:     taken_c = eq;
                        BNE:     taken_c = !eq;
                        BLT:     taken_c = lt;
                        BGE:     taken_c = !lt;
                        BLTU:    taken_c = ltu;
                        BGEU:    taken_c = !ltu;
                        default: cond_c  = 1'b0;
                    endcase
                    train_c = cond_c;
                    if (cond_c && taken_c && !ex_pred_taken)
                        redir_c = REDIR_TARGET;
                    else if (cond_c && !taken_c && ex_pred_taken)
                        redir_c = REDIR_SEQ;
                end
                JAL, JALR: begin
                    taken_c = 1'b1;
                    redir_c = REDIR_TARGET;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            br_redir    <= REDIR_NONE;
            br_flush    <= 1'b0;
            br_taken    <= 1'b0;
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else begin
            br_redir <= redir_c;
            br_flush <= redir_c != REDIR_NONE;
            br_taken <= taken_c;
            if (train_c && branch_cnt != '1)
                branch_cnt <= branch_cnt + ONE;
            if (train_c && redir_c != REDIR_NONE && mispred_cnt != '1)
                mispred_cnt <= mispred_cnt + ONE;
        end
    end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Scoreboard bench for branch_predict_unit against an array-based
// model of the predictor table and statistics (CNT_W=4 build).
module tb_branch_predict_unit;

    localparam int XLEN  = 32;
    localparam int DEPTH = 64;
    localparam int CW    = 4;

    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_ADD  = 7'b0110011;
    localparam logic [6:0] OP_LD   = 7'b0000011;

    bit              CLK;
    logic            RST;
    logic [XLEN-1:0] if_pc;
    logic            if_pred_taken;
    logic            ex_valid;
    logic [XLEN-1:0] ex_pc;
    logic [6:0]      ex_opcode;
    logic [2:0]      ex_func3;
    logic [XLEN-1:0] ex_rs1, ex_rs2;
    logic            ex_pred_taken;
    logic [1:0]      br_redir;
    logic            br_flush, br_taken;
    logic [CW-1:0]   branch_cnt, mispred_cnt;

    branch_predict_unit #(.XLEN(XLEN), .BHT_DEPTH(DEPTH), .CNT_W(CW)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .if_pc         (if_pc),
        .if_pred_taken (if_pred_taken),
        .ex_valid      (ex_valid),
        .ex_pc         (ex_pc),
        .ex_opcode     (ex_opcode),
        .ex_func3      (ex_func3),
        .ex_rs1        (ex_rs1),
        .ex_rs2        (ex_rs2),
        .ex_pred_taken (ex_pred_taken),
        .br_redir      (br_redir),
        .br_flush      (br_flush),
        .br_taken      (br_taken),
        .branch_cnt    (branch_cnt),
        .mispred_cnt   (mispred_cnt)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit       pchk;
        bit       pred;
        bit [1:0] redir;
        bit       flush;
        bit       taken;
        int       bc;
        int       mc;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference state: strength 0..3 per entry, plain integer counts.
    int tbl [DEPTH];
    int m_bc, m_mc;
    bit tbl_known = 0;

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic issue(input bit rst, input bit v, input logic [31:0] pc,
                         input logic [6:0] op, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b,
                         input bit pred, input logic [31:0] ipc);
        exp_t e;
        bit   tk, cond;
        int   idx;
        @(posedge CLK);
        #1;
        RST = rst; ex_valid = v; ex_pc = pc; ex_opcode = op;
        ex_func3 = f3; ex_rs1 = a; ex_rs2 = b;
        ex_pred_taken = pred; if_pc = ipc;
        e.pchk = tbl_known;
        e.pred = tbl[(ipc / 4) % DEPTH] >= 2;
        tk = 0;
        e.redir = 0;
        if (rst) begin
            foreach (tbl[i]) tbl[i] = 1;
            m_bc = 0;
            m_mc = 0;
            tbl_known = 1;
        end else if (v && op == OP_BR) begin
            cond = 1;
            case (f3)
                3'd0: tk = a == b;
                3'd1: tk = a != b;
                3'd4: tk = $signed(a) < $signed(b);
                3'd5: tk = $signed(a) >= $signed(b);
                3'd6: tk = a < b;
                3'd7: tk = a >= b;
                default: cond = 0;
            endcase
            if (cond) begin
                idx = (pc / 4) % DEPTH;
                tbl[idx] = tk ? ((tbl[idx] < 3) ? tbl[idx] + 1 : 3)
                              : ((tbl[idx] > 0) ? tbl[idx] - 1 : 0);
                m_bc = (m_bc < 15) ? m_bc + 1 : 15;
                if (tk != pred) begin
                    m_mc = (m_mc < 15) ? m_mc + 1 : 15;
                    e.redir = tk ? 2'b01 : 2'b10;
                end
            end
        end else if (v && (op == OP_JAL || op == OP_JALR)) begin
            tk = 1;
            e.redir = 2'b01;
        end
        e.taken = tk;
        e.flush = e.redir != 0;
        e.bc = m_bc;
        e.mc = m_mc;
        q.push_back(e);
    endtask

    task automatic br(input logic [31:0] pc, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] b, input bit pred);
        issue(0, 1, pc, OP_BR, f3, a, b, pred, pc);
    endtask

    // Monitor: pred checked while its cycle's inputs are applied,
    // registered outputs checked one cycle later.
    initial begin
        exp_t pend;
        bit   have = 0;
        forever begin
            @(negedge CLK);
            if (have) begin
                check("br_redir", br_redir, pend.redir);
                check("br_flush", br_flush, pend.flush);
                check("br_taken", br_taken, pend.taken);
                check("branch_cnt", branch_cnt, pend.bc);
                check("mispred_cnt", mispred_cnt, pend.mc);
            end
            have = 0;
            if (q.size() > 0) begin
                pend = q.pop_front();
                have = 1;
                if (pend.pchk)
                    check("if_pred_taken", if_pred_taken, pend.pred);
            end
        end
    end

    initial begin
        logic [31:0] a, b, pc;
        logic [6:0]  op;
        int          r;
        RST = 1; ex_valid = 0; ex_pc = 0; ex_opcode = 0; ex_func3 = 0;
        ex_rs1 = 0; ex_rs2 = 0; ex_pred_taken = 0; if_pc = 0;

        issue(1, 0, 0, 0, 0, 0, 0, 0, 32'h100);
        issue(0, 0, 0, 0, 0, 0, 0, 0, 32'h100);
        br(32'h100, 3'd0, 5, 5, 0);
        issue(0, 0, 0, 0, 0, 0, 0, 0, 32'h100);
        br(32'h104, 3'd4, 32'hFFFF_FFFF, 1, 1);
        br(32'h108, 3'd6, 32'hFFFF_FFFF, 1, 1);
        repeat (4) br(32'h200, 3'd1, 1, 2, 1);
        br(32'h200, 3'd1, 3, 3, 1);
        issue(0, 0, 0, 0, 0, 0, 0, 0, 32'h200);
        issue(0, 1, 32'h200, OP_JAL, 0, 0, 0, 0, 32'h200);
        issue(0, 1, 32'h200, OP_JAL, 0, 0, 0, 1, 32'h200);
        issue(0, 1, 32'h200, OP_JALR, 3'd0, 0, 0, 0, 32'h200);
        issue(0, 1, 32'h200, OP_JALR, 3'd0, 0, 0, 1, 32'h200);
        issue(0, 1, 32'h300, OP_BR, 3'd2, 7, 7, 1, 32'h300);
        issue(0, 1, 32'h300, OP_BR, 3'd3, 7, 8, 0, 32'h300);
        issue(0, 0, 32'h300, OP_BR, 3'd0, 9, 9, 0, 32'h300);
        issue(1, 1, 32'h300, OP_BR, 3'd1, 1, 2, 0, 32'h300);
        issue(0, 0, 0, 0, 0, 0, 0, 0, 32'h300);
        for (int i = 0; i < 16; i++)
            br(32'h400, 3'd0, 1, 1, 0);
        br(32'h404, 3'd0, 1, 2, 1);
        issue(0, 0, 0, 0, 0, 0, 0, 0, 32'h404);

        for (int i = 0; i < 400; i++) begin
            r  = $urandom_range(0, 9);
            op = (r < 6) ? OP_BR : (r == 6) ? OP_JAL : (r == 7) ? OP_JALR
               : (r == 8) ? OP_ADD : OP_LD;
            pc = 32'h1000 + ($urandom_range(0, 7) << 2) + ($urandom_range(0, 1) << 8);
            a  = ($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(0, 3);
            b  = ($urandom_range(0, 2) == 0) ? a : $urandom_range(0, 3);
            if ($urandom_range(0, 4) == 0) b = $urandom;
            issue($urandom_range(0, 59) == 0, $urandom_range(0, 7) != 0, pc, op,
                  3'($urandom_range(0, 7)), a, b, $urandom_range(0, 1) == 1,
                  ($urandom_range(0, 1) == 1) ? pc
                      : 32'h1000 + ($urandom_range(0, 7) << 2));
        end
        issue(0, 0, 0, 0, 0, 0, 0, 0, 0);

        repeat (4) @(negedge CLK);
        #1;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/branch_predict_unit.md
# branch_predict_unit

Second-generation branch unit for the OTTER pipeline: resolves conditional branches and jumps in execute, and owns a bimodal predictor (table of 2-bit saturating counters) that fetch consults. Compares predicted against actual direction, drives a registered redirect code to the PC mux, trains the table, and keeps branch/mispredict statistics. Sits between the decode/execute pipeline registers and the PC-select logic.

## Interface
- `XLEN`, 32, data and PC width
- `BHT_DEPTH`, 64, predictor entries; power of two, ≥2
- `CNT_W`, 32, statistics counter width
- `CLK`  in  1  sole clock, rising edge
- `RST`  in  1  reset, synchronous, active-high
- `if_pc`  in  XLEN  fetch PC for lookup
- `if_pred_taken`  out  1  MSB of counter indexed by `if_pc`; combinational
- `ex_valid`  in  1  execute-stage instruction valid (not squashed)
- `ex_pc`  in  XLEN  PC of the execute-stage instruction
- `ex_opcode`  in  7  RV32I opcode
- `ex_func3`  in  3  funct3
- `ex_rs1`, `ex_rs2`  in  XLEN each  forwarded operands
- `ex_pred_taken`  in  1  prediction made at fetch, carried down the pipe
- `br_redir`  out  2  00 none, 01 go to computed target, 10 go to `ex_pc`+4
- `br_flush`  out  1  squash younger instructions
- `br_taken`  out  1  actual direction of the resolved instruction
- `branch_cnt`  out  CNT_W  resolved conditional branches
- `mispred_cnt`  out  CNT_W  mispredicted conditional branches

## Operation
- Index = `pc[$clog2(BHT_DEPTH)+1:2]`; same function for fetch and execute.
- Counters: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T; predict taken iff MSB=1.
- Compare: eq = rs1==rs2; lt signed; ltu unsigned; all XLEN wide.
- BRANCH (1100011) func3 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
  - taken & !pred → redir 01, flush 1; !taken & pred → redir 10, flush 1; agree → redir 00, flush 0.
  - Train indexed counter: +1 if taken (saturate at 11), −1 if not (saturate at 00).
  - `branch_cnt` +1; `mispred_cnt` +1 on disagreement.
- BRANCH with func3 010/011: not taken, redir 00, no train, no count.
- JAL (1101111), JALR (1100111): taken=1, redir 01, flush 1; `ex_pred_taken` ignored; no train, no count.
- Any other opcode, or `ex_valid`=0: redir 00, flush 0, taken 0; no train, no count.
- Statistics counters saturate at all-ones, never wrap.

## Timing
- Resolution latency 1: inputs sampled at edge N, `br_redir`/`br_flush`/`br_taken` valid from N until N+1; single-cycle pulses, no holding.
- Table and statistics update at the same edge as outputs register.
- Same-cycle read/write of one index: `if_pred_taken` returns pre-update value; new value visible next cycle.
- Back-to-back valid instructions each resolve independently; no stall, no ready signal.
- `RST` at an edge: outputs 0, statistics 0, every counter 01; dominates a simultaneous valid resolution (no train, no count, no redirect).
- No internal state machine beyond counters; pipeline must deassert `ex_valid` for instructions squashed by `br_flush`.

## Structure
- `branch_pkg`: `opcode_t` enum (LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP_RG3, SYS), `br_func3_t` enum, `redir_t` enum {REDIR_NONE=00, REDIR_TARGET=01, REDIR_SEQ=10}, 2-bit counter reset constant.
- Sub-module `bht_2bit` (params DEPTH; async read port, sync write port with saturating inc/dec, sync reset to 01); top holds compare, decision, output regs, statistics.

## Test plan
- Post-reset: `if_pc`=0x100 → `if_pred_taken`=0; BEQ at 0x100, rs1=rs2=5, pred 0 → next cycle redir 01, flush 1, branch_cnt 1, mispred_cnt 1; counter 10, `if_pred_taken`=1.
- BLT rs1=0xFFFFFFFF, rs2=1, pred 1 → taken, redir 00, flush 0; BLTU same operands, pred 1 → not taken, redir 10, mispred_cnt +1.
- Four consecutive taken BNE at 0x200 → counter saturates 11; one not-taken → 10, prediction still taken.
- JAL and JALR with `ex_pred_taken`=0 and =1 → redir 01, flush 1, counts unchanged, table unchanged; func3 010 BRANCH → all outputs 0.
- `ex_valid`=0 with taken BEQ → no redirect, no count; `RST` asserted same cycle as valid mispredicted BNE → outputs 0, counts 0, counter 01.
- Force `mispred_cnt` near all-ones (CNT_W=4 build): 16 mispredicts → holds at 0xF.
